// File: rtl/lfsr4_seq_checker_if.sv
// Sample stream and checker status bus between an LFSR sequence source and lfsr4_seq_checker.
// The master drives samples; the slave (checker) returns lock, error and prediction status.
interface lfsr4_seq_checker_if #(
    parameter int CNT_W = 8
);
    logic             D_VALID;
    logic [3:0]       D;
    logic             LOCKED;
    logic             ERR;
    logic [CNT_W-1:0] ERR_CNT;
    logic [3:0]       EXP;

    modport master (output D_VALID, D, input LOCKED, ERR, ERR_CNT, EXP);
    modport slave  (input D_VALID, D, output LOCKED, ERR, ERR_CNT, EXP);
endinterface

// File: rtl/lfsr4_seq_checker.sv
// Receive-side checker for the 4-bit maximal-length LFSR sequence next(x) = {x[2:0], x[3]^x[2]}.
// Hunts for a seed, verifies a run of predicted values, then flywheels through errors while locked.
module lfsr4_seq_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic               CLK,
    input  logic               RST,
    lfsr4_seq_checker_if.slave bus
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    function automatic logic [3:0] lfsr_next(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [3:0]       xcnt_q, xcnt_d;
    logic [3:0]       exp_q, exp_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= HUNT;
            mcnt_q   <= '0;
            xcnt_q   <= '0;
            exp_q    <= '0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcnt_q   <= mcnt_d;
            xcnt_q   <= xcnt_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        xcnt_d  = xcnt_q;
        exp_d   = exp_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (bus.D_VALID) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.D != 4'd0) begin
                        exp_d   = lfsr_next(bus.D);
                        mcnt_d  = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (bus.D == exp_q) begin
                        mcnt_d = mcnt_q + 4'd1;
                        exp_d  = lfsr_next(bus.D);
                        if (mcnt_q + 4'd1 == LOCK_N) begin
                            state_d = LOCK;
                            xcnt_d  = '0;
                        end
                    end else if (bus.D != 4'd0) begin
                        exp_d  = lfsr_next(bus.D);
                        mcnt_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCK: begin
                    // Prediction always advances from our own state, never from corrupt data.
                    exp_d = lfsr_next(exp_q);
                    if (bus.D == exp_q) begin
                        xcnt_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        xcnt_d = xcnt_q + 4'd1;
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                        if (xcnt_q + 4'd1 == LOSS_N) state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCK);
    end

    assign bus.LOCKED  = locked_q;
    assign bus.ERR     = err_q;
    assign bus.ERR_CNT = cnt_q;
    assign bus.EXP     = exp_q;
endmodule

// File: tb/tb_lfsr4_seq_checker.sv
// Directed bench for lfsr4_seq_checker: two instances (8-bit and 2-bit error counters) share one
// stimulus stream and are checked every cycle against a table-driven sequence model.
module tb_lfsr4_seq_checker;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       dv  = 1'b0;
    logic [3:0] d   = 4'd0;

    int total = 0;
    int bad   = 0;

    lfsr4_seq_checker_if #(.CNT_W(8)) if0 ();
    lfsr4_seq_checker_if #(.CNT_W(2)) if1 ();
    assign if0.D_VALID = dv;
    assign if0.D       = d;
    assign if1.D_VALID = dv;
    assign if1.D       = d;

    lfsr4_seq_checker #(.LOCK_COUNT(3), .LOSS_COUNT(4), .CNT_W(8)) u0 (.CLK(CLK), .RST(RST), .bus(if0));
    lfsr4_seq_checker #(.LOCK_COUNT(3), .LOSS_COUNT(4), .CNT_W(2)) u1 (.CLK(CLK), .RST(RST), .bus(if1));

    always #5 CLK = ~CLK;

    // The full period-15 sequence, written out by hand starting at 0001.
    int seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

    function automatic int succ(input int v);
        for (int i = 0; i < 15; i++)
            if (seq[i] == v) return seq[(i + 1) % 15];
        return 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0=searching, 1=confirming, 2=locked; run = confirmed matches, miss = consecutive misses.
    int mode [2] = '{0, 0};
    int pred [2] = '{0, 0};
    int run  [2] = '{0, 0};
    int miss [2] = '{0, 0};
    int errs [2] = '{0, 0};
    int eflag[2] = '{0, 0};
    int cmax [2] = '{255, 3};

    always @(posedge CLK or negedge RST) begin
        for (int k = 0; k < 2; k++) begin
            if (!RST) begin
                mode[k] = 0; pred[k] = 0; run[k] = 0; miss[k] = 0; errs[k] = 0; eflag[k] = 0;
            end else begin
                eflag[k] = 0;
                if (dv) begin
                    if (mode[k] == 0) begin
                        if (d != 0) begin pred[k] = succ(int'(d)); run[k] = 0; mode[k] = 1; end
                    end else if (mode[k] == 1) begin
                        if (int'(d) == pred[k]) begin
                            run[k]++;
                            pred[k] = succ(int'(d));
                            if (run[k] == 3) begin mode[k] = 2; miss[k] = 0; end
                        end else if (d != 0) begin
                            pred[k] = succ(int'(d)); run[k] = 0;
                        end else mode[k] = 0;
                    end else begin
                        if (int'(d) == pred[k]) miss[k] = 0;
                        else begin
                            eflag[k] = 1;
                            if (errs[k] < cmax[k]) errs[k]++;
                            miss[k]++;
                            if (miss[k] == 4) mode[k] = 0;
                        end
                        pred[k] = succ(pred[k]);
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        chk("u0.LOCKED",  int'(if0.LOCKED),  int'(mode[0] == 2));
        chk("u0.ERR",     int'(if0.ERR),     eflag[0]);
        chk("u0.ERR_CNT", int'(if0.ERR_CNT), errs[0]);
        chk("u0.EXP",     int'(if0.EXP),     pred[0]);
        chk("u1.LOCKED",  int'(if1.LOCKED),  int'(mode[1] == 2));
        chk("u1.ERR",     int'(if1.ERR),     eflag[1]);
        chk("u1.ERR_CNT", int'(if1.ERR_CNT), errs[1]);
        chk("u1.EXP",     int'(if1.EXP),     pred[1]);
    end

    task automatic send(input logic [3:0] v);
        dv = 1'b1;
        d  = v;
        @(posedge CLK);
        #1;
        dv = 1'b0;
    endtask

    task automatic gap(input int n);
        dv = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pin(input string nm, input int lk, input int er, input int cnt, input int ex);
        chk({nm, ".LOCKED"},  int'(if0.LOCKED),  lk);
        chk({nm, ".ERR"},     int'(if0.ERR),     er);
        chk({nm, ".ERR_CNT"}, int'(if0.ERR_CNT), cnt);
        chk({nm, ".EXP"},     int'(if0.EXP),     ex);
    endtask

    int sat_cnt [5] = '{1, 2, 3, 3, 3};
    int sat_exp [5] = '{1, 4, 3, 13, 5};
    logic [3:0] fix;

    initial begin
        #1 RST = 1'b1;
        #1 pin("reset", 0, 0, 0, 0);
        @(negedge CLK);

        // Acquire: 0001,0010,0100,1001 -> EXP 0010,0100,1001,0011, lock on 4th.
        send(4'd1);  pin("acq1", 0, 0, 0, 2);
        send(4'd2);  pin("acq2", 0, 0, 0, 4);
        send(4'd4);  pin("acq3", 0, 0, 0, 9);
        send(4'd9);  pin("acq4", 1, 0, 0, 3);
        send(4'd3);
        gap(3);      pin("gap", 1, 0, 0, 6);
        send(4'd6);  pin("after_gap", 1, 0, 0, 13);

        // Single corrupted sample: flywheel past it.
        send(4'd0);  pin("fly_err", 1, 1, 1, 10);
        send(4'd10); pin("fly_ok", 1, 0, 1, 5);

        // Three misses then a match on 1111 keeps lock.
        for (int i = 0; i < 4; i++) send(4'd15);
        pin("xf_match", 1, 0, 4, 14);

        // Advance to EXP=0010 so four 0001 samples all miss.
        send(4'd14); send(4'd12); send(4'd8); send(4'd1);
        pin("pre_loss", 1, 0, 4, 2);
        for (int i = 0; i < 3; i++) send(4'd1);
        pin("loss3", 1, 1, 7, 3);
        send(4'd1);  pin("loss4", 0, 1, 8, 6);

        // Reacquire keeps the error count.
        send(4'd14); pin("relock1", 0, 0, 8, 12);
        send(4'd12); send(4'd8); send(4'd1);
        pin("relock", 1, 0, 8, 2);

        // Asynchronous reset mid-LOCK.
        #1 RST = 1'b0;
        #1 pin("async_rst", 0, 0, 0, 0);
        chk("async_rst.u1cnt", int'(if1.ERR_CNT), 0);
        #1 RST = 1'b1;
        @(negedge CLK);

        // VERIFY reseed: 0001,0010,0111,1111,1110,1100 locks only on 1100.
        send(4'd1); send(4'd2);
        send(4'd7);  pin("reseed", 0, 0, 0, 15);
        send(4'd15); send(4'd14);
        pin("reseed_pre", 0, 0, 0, 12);
        send(4'd12); pin("reseed_lock", 1, 0, 0, 8);

        // Saturation on the 2-bit counter: isolated misses, each followed by a match.
        for (int i = 0; i < 5; i++) begin
            send(4'd0);
            chk("sat.ERR", int'(if1.ERR), 1);
            chk("sat.ERR_CNT", int'(if1.ERR_CNT), sat_cnt[i]);
            chk("sat.EXP", int'(if1.EXP), sat_exp[i]);
            fix = if1.EXP;
            send(fix);
            chk("sat.LOCKED", int'(if1.LOCKED), 1);
        end
        chk("sat.u0cnt", int'(if0.ERR_CNT), 5);

        gap(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
